// File: rtl/id_stage.sv
// id_stage: MIPS32-subset decode, regfile read initiation, EX/MEM forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_valid_i,
  input  logic [31:0]   inst_i,
  input  logic [31:0]   pc_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          re1_o,
  output logic          re2_o,
  output logic [AW-1:0] raddr1_o,
  output logic [AW-1:0] raddr2_o,
  input  logic [DW-1:0] rdata1_i,
  input  logic [DW-1:0] rdata2_i,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          ex_is_load_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic          stall_req_o,
  output logic          ex_valid_o,
  output logic [3:0]    ex_aluop_o,
  output logic [DW-1:0] ex_op1_o,
  output logic [DW-1:0] ex_op2_o,
  output logic          ex_we_o,
  output logic [AW-1:0] ex_waddr_o,
  output logic [31:0]   ex_pc_o
);
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR = 4'd4, OP_XOR = 4'd5, OP_LOAD = 4'd6;
  logic [5:0]    opc, funct;
  logic [AW-1:0] rs, rt, rd;
  logic [3:0]    r_op, aluop_d;
  logic          re1, re2, wr;
  logic [AW-1:0] wa;
  logic [DW-1:0] imm, fwd1, fwd2, op1_d, op2_d;
  logic          we_d, bubble;
  logic          ex_valid_q, ex_we_q;
  logic [3:0]    ex_aluop_q;
  logic [DW-1:0] ex_op1_q, ex_op2_q;
  logic [AW-1:0] ex_waddr_q;
  logic [31:0]   ex_pc_q;
  assign opc   = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  always_comb begin
    r_op = funct == 6'b100001 ? OP_ADD :
           funct == 6'b100011 ? OP_SUB :
           funct == 6'b100100 ? OP_AND :
           funct == 6'b100101 ? OP_OR  :
           funct == 6'b100110 ? OP_XOR : OP_NOP;
  end
  always_comb begin
    aluop_d = OP_NOP;
    re1     = 1'b0;
    re2     = 1'b0;
    wr      = 1'b0;
    wa      = '0;
    imm     = '0;
    if (inst_valid_i) begin
      case (opc)
        6'b000000: if (r_op != OP_NOP) begin
          aluop_d = r_op;
          re1     = 1'b1;
          re2     = 1'b1;
          wr      = 1'b1;
          wa      = rd;
        end
        6'b001101: begin
          aluop_d = OP_OR;
          re1     = 1'b1;
          wr      = 1'b1;
          wa      = rt;
          imm     = DW'(inst_i[15:0]);
        end
        6'b001001: begin
          aluop_d = OP_ADD;
          re1     = 1'b1;
          wr      = 1'b1;
          wa      = rt;
          imm     = DW'($signed(inst_i[15:0]));
        end
        6'b001111: begin
          aluop_d = OP_OR;
          wr      = 1'b1;
          wa      = rt;
          imm     = DW'({inst_i[15:0], 16'h0000});
        end
        6'b100011: begin
          aluop_d = OP_LOAD;
          re1     = 1'b1;
          wr      = 1'b1;
          wa      = rt;
          imm     = DW'($signed(inst_i[15:0]));
        end
        default: aluop_d = OP_NOP;
      endcase
    end
  end
  assign re1_o    = re1;
  assign re2_o    = re2;
  assign raddr1_o = re1 ? rs : '0;
  assign raddr2_o = re2 ? rt : '0;
  // $0 reads as zero even if an in-flight stage claims to write it
  assign fwd1 = raddr1_o == '0 ? '0 :
                (ex_we_i && ex_waddr_i == raddr1_o) ? ex_wdata_i :
                (mem_we_i && mem_waddr_i == raddr1_o) ? mem_wdata_i : rdata1_i;
  assign fwd2 = raddr2_o == '0 ? '0 :
                (ex_we_i && ex_waddr_i == raddr2_o) ? ex_wdata_i :
                (mem_we_i && mem_waddr_i == raddr2_o) ? mem_wdata_i : rdata2_i;
  assign op1_d = re1 ? fwd1 : '0;
  assign op2_d = re2 ? fwd2 : imm;
  assign we_d  = wr && wa != '0;
  assign stall_req_o = inst_valid_i && ex_is_load_i && ex_we_i && ex_waddr_i != '0 &&
                       ((re1 && raddr1_o == ex_waddr_i) || (re2 && raddr2_o == ex_waddr_i));
  // a load-use hazard inserts a bubble while upstream holds the instruction
  assign bubble = flush_i || (!stall_i && stall_req_o);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_aluop_q <= OP_NOP;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_we_q    <= 1'b0;
      ex_waddr_q <= '0;
      ex_pc_q    <= '0;
    end else if (bubble) begin
      ex_valid_q <= 1'b0;
      ex_aluop_q <= OP_NOP;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_we_q    <= 1'b0;
      ex_waddr_q <= '0;
      ex_pc_q    <= '0;
    end else if (!stall_i) begin
      ex_valid_q <= inst_valid_i;
      ex_aluop_q <= aluop_d;
      ex_op1_q   <= op1_d;
      ex_op2_q   <= op2_d;
      ex_we_q    <= we_d;
      ex_waddr_q <= wa;
      ex_pc_q    <= pc_i;
    end
  end
  assign ex_valid_o = ex_valid_q;
  assign ex_aluop_o = ex_aluop_q;
  assign ex_op1_o   = ex_op1_q;
  assign ex_op2_o   = ex_op2_q;
  assign ex_we_o    = ex_we_q;
  assign ex_waddr_o = ex_waddr_q;
  assign ex_pc_o    = ex_pc_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, stall_i, flush_i;
  logic [31:0] inst_i, pc_i;
  logic        re1_o, re2_o;
  logic [4:0]  raddr1_o, raddr2_o;
  logic [31:0] rdata1_i, rdata2_i;
  logic        ex_we_i, ex_is_load_i, mem_we_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        stall_req_o, ex_valid_o, ex_we_o;
  logic [3:0]  ex_aluop_o;
  logic [31:0] ex_op1_o, ex_op2_o, ex_pc_o;
  logic [4:0]  ex_waddr_o;
  int vectors = 0;
  int errors  = 0;
  id_stage dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .re1_o(re1_o), .re2_o(re2_o),
    .raddr1_o(raddr1_o), .raddr2_o(raddr2_o), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i), .stall_req_o(stall_req_o), .ex_valid_o(ex_valid_o),
    .ex_aluop_o(ex_aluop_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_we_o(ex_we_o),
    .ex_waddr_o(ex_waddr_o), .ex_pc_o(ex_pc_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idex(input string tag, input logic v, input logic [3:0] op,
                      input logic [31:0] o1, input logic [31:0] o2, input logic w, input logic [4:0] wa);
    chk({tag, ".valid"}, 32'(ex_valid_o), 32'(v));
    chk({tag, ".aluop"}, 32'(ex_aluop_o), 32'(op));
    chk({tag, ".op1"}, ex_op1_o, o1);
    chk({tag, ".op2"}, ex_op2_o, o2);
    chk({tag, ".we"}, 32'(ex_we_o), 32'(w));
    chk({tag, ".waddr"}, 32'(ex_waddr_o), 32'(wa));
  endtask
  initial begin
    rst = 1'b1; inst_valid_i = 0; inst_i = 0; pc_i = 0; stall_i = 0; flush_i = 0;
    rdata1_i = 0; rdata2_i = 0; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
    #1 rst = 1'b0;
    tick(); tick();
    idex("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.pc", ex_pc_o, 0);
    rst = 1'b1;
    inst_valid_i = 1; inst_i = 32'h34018000; pc_i = 32'h100;
    #1;
    chk("ori.re1", 32'(re1_o), 1);
    chk("ori.raddr1", 32'(raddr1_o), 0);
    chk("ori.re2", 32'(re2_o), 0);
    tick();
    idex("ori", 1, 4, 0, 32'h00008000, 1, 1);
    chk("ori.pc", ex_pc_o, 32'h100);
    #2 rst = 1'b0;
    #1;
    idex("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst.pc", ex_pc_o, 0);
    tick();
    idex("rst_hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    inst_i = 32'h2402FFFF; pc_i = 32'h104;
    tick();
    idex("addiu", 1, 1, 0, 32'hFFFFFFFF, 1, 2);
    inst_i = 32'h3C031234; pc_i = 32'h108;
    #1;
    chk("lui.re1", 32'(re1_o), 0);
    chk("lui.raddr1", 32'(raddr1_o), 0);
    tick();
    idex("lui", 1, 4, 0, 32'h12340000, 1, 3);
    inst_i = 32'h00221821;
    ex_we_i = 1; ex_waddr_i = 1; ex_wdata_i = 32'hAAAA;
    mem_we_i = 1; mem_waddr_i = 2; mem_wdata_i = 32'h7777;
    #1;
    chk("addu.raddr1", 32'(raddr1_o), 1);
    chk("addu.raddr2", 32'(raddr2_o), 2);
    chk("addu.re2", 32'(re2_o), 1);
    tick();
    idex("fwd_ex_mem", 1, 1, 32'hAAAA, 32'h7777, 1, 3);
    mem_waddr_i = 1; mem_wdata_i = 32'h5555; rdata2_i = 32'h1234;
    tick();
    idex("fwd_ex_prio", 1, 1, 32'hAAAA, 32'h1234, 1, 3);
    ex_we_i = 0;
    tick();
    idex("fwd_mem", 1, 1, 32'h5555, 32'h1234, 1, 3);
    mem_we_i = 0;
    ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 4;
    #1;
    chk("load_nomatch.stall", 32'(stall_req_o), 0);
    ex_waddr_i = 1;
    #1;
    chk("load_use.stall", 32'(stall_req_o), 1);
    tick();
    idex("load_use", 0, 0, 0, 0, 0, 0);
    ex_is_load_i = 0;
    #1;
    chk("load_clear.stall", 32'(stall_req_o), 0);
    tick();
    idex("load_clear", 1, 1, 32'hAAAA, 32'h1234, 1, 3);
    ex_we_i = 0; flush_i = 1; stall_i = 1;
    tick();
    idex("flush_stall", 0, 0, 0, 0, 0, 0);
    flush_i = 0; stall_i = 0;
    inst_i = 32'h00221823; rdata1_i = 32'h10; rdata2_i = 32'h3; pc_i = 32'h200;
    tick();
    idex("sub", 1, 2, 32'h10, 32'h3, 1, 3);
    stall_i = 1; inst_i = 32'h3C031234; pc_i = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tick();
      idex("stall_hold", 1, 2, 32'h10, 32'h3, 1, 3);
      chk("stall_hold.pc", ex_pc_o, 32'h200);
    end
    stall_i = 0;
    inst_i = 32'h34018000; ex_we_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hDEAD; rdata1_i = 32'h99;
    tick();
    idex("zero_reg", 1, 4, 0, 32'h00008000, 1, 1);
    ex_we_i = 0;
    inst_i = 32'h8C22FFF0; rdata1_i = 32'h1000;
    tick();
    idex("lw", 1, 6, 32'h1000, 32'hFFFFFFF0, 1, 2);
    inst_i = 32'h34200005; rdata1_i = 32'h7;
    tick();
    idex("ori_to_r0", 1, 4, 32'h7, 32'h5, 0, 0);
    inst_i = 32'hFC000000;
    tick();
    idex("bad_opcode", 1, 0, 0, 0, 0, 0);
    inst_valid_i = 0; inst_i = 32'h00221821;
    #1;
    chk("invalid.re1", 32'(re1_o), 0);
    chk("invalid.raddr2", 32'(raddr2_o), 0);
    tick();
    idex("invalid", 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
